alu_rr_arbiter8: RTL and testbench

Round-robin arbiter that shares the single ALU datapath among eight requesters. It picks one requester, holds the grant until the ALU signals completion or a watchdog expires, then rotates priority. The grant index drives the operand/opcode muxes in front of the ALU. The one-hot grant is produced by the library 3-to-8 decoder.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/decoder3.sv | 15 +
 rtl/rr_pick8.sv | 33 +++
 rtl/alu_rr_arbiter8.sv | 106 ++++++++++
 tb/tb_alu_rr_arbiter8.sv | 125 ++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants and state encoding for the ALU round-robin arbiter.
package alu_arb_pkg;

  localparam int unsigned N_REQ = 8;  // number of requesters
  localparam int unsigned IDX_W = 3;  // width of a requester index
  localparam int unsigned CNT_W = 8;  // width of the watchdog counter

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder3.sv
// Library 3-to-8 binary-to-one-hot decoder.
// Ports:
//   sel_i    - binary select
//   onehot_o - one-hot output, bit sel_i set
module decoder3 (
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotating-priority selector. Scans REQ starting at PTR, then
// PTR+1, ... wrapping modulo 8, and reports the first set requester.
// Ports:
//   REQ - request vector
//   PTR - index holding highest priority
//   ANY - at least one request is set
//   IDX - index of the winning requester (PTR when ANY=0)
module rr_pick8
  import alu_arb_pkg::*;
(
  input  logic [N_REQ-1:0] REQ,
  input  logic [IDX_W-1:0] PTR,
  output logic             ANY,
  output logic [IDX_W-1:0] IDX
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    ANY  = 1'b0;
    IDX  = PTR;
    cand = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      // Index arithmetic wraps naturally at IDX_W bits.
      cand = PTR + IDX_W'(k);
      if (!ANY && REQ[cand]) begin
        ANY = 1'b1;
        IDX = cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter8.sv
// Round-robin arbiter sharing the ALU datapath among eight requesters.
// A grant is held until DONE or the watchdog expires, then priority rotates
// to the requester after the one just served.
// Ports:
//   CLK         - clock, rising edge
//   RST_N       - synchronous active-low reset
//   REQ         - level requests, bit i for requester i
//   DONE        - one-cycle completion pulse from the ALU sequencer
//   GNT         - one-hot grant, zero when no grant is held
//   GNT_IDX     - binary index of the (last) granted requester
//   GNT_VALID   - a grant is held
//   TIMEOUT_ERR - one-cycle pulse when the watchdog forced a release
// Parameter TIMEOUT: BUSY cycles per grant before forced release, 0 disables.
module alu_rr_arbiter8
  import alu_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [N_REQ-1:0] GNT,
  output logic [IDX_W-1:0] GNT_IDX,
  output logic             GNT_VALID,
  output logic             TIMEOUT_ERR
);

  localparam bit              WdEn     = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WdLast  = WdEn ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] dec;
  logic             wd_hit;

  rr_pick8 u_pick (
    .REQ (REQ),
    .PTR (ptr_q),
    .ANY (pick_any),
    .IDX (pick_idx)
  );

  assign wd_hit = WdEn && (cnt_q == WdLast);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (DONE || wd_hit) begin
          state_d = StIdle;
          ptr_d   = idx_q + IDX_W'(1);
          // DONE takes precedence over a coincident timeout.
          err_d   = !DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  decoder3 u_dec (
    .sel_i    (idx_q),
    .onehot_o (dec)
  );

  assign GNT_VALID   = (state_q == StBusy);
  assign GNT_IDX     = idx_q;
  assign GNT         = dec & {N_REQ{GNT_VALID}};
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_alu_rr_arbiter8.sv
module tb_alu_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  alu_rr_arbiter8 #(.TIMEOUT(4)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .REQ         (req),
    .DONE        (done),
    .GNT         (gnt),
    .GNT_IDX     (gnt_idx),
    .GNT_VALID   (gnt_valid),
    .TIMEOUT_ERR (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, step, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] q, input logic d, input logic [7:0] g,
                     input logic [2:0] i, input logic v, input logic e);
    vec_t t;
    t.rst_n = r; t.req = q; t.done = d; t.gnt = g; t.idx = i; t.valid = v; t.err = e;
    vecs.push_back(t);
  endtask

  // Drive inputs mid-cycle, clock once, sample just after the edge.
  task automatic step(input int n, input logic r, input logic [7:0] q, input logic d,
                      input logic [7:0] g, input logic [2:0] i, input logic v,
                      input logic e);
    @(negedge clk);
    rst_n = r; req = q; done = d;
    @(posedge clk);
    #1;
    chk("gnt", n, 32'(gnt), 32'(g));
    chk("gnt_idx", n, 32'(gnt_idx), 32'(i));
    chk("gnt_valid", n, 32'(gnt_valid), 32'(v));
    chk("timeout_err", n, 32'(timeout_err), 32'(e));
  endtask

  initial begin
    logic [7:0] oh;
    rst_n = 1'b0; req = '0; done = 1'b0;

    // Reset with everything asserted.
    add(0, 8'hFF, 1, 8'h00, 0, 0, 0);
    add(0, 8'hFF, 1, 8'h00, 0, 0, 0);
    // Rotation: grant, hold, DONE; nine grants 0..7,0.
    for (int g = 0; g < 9; g++) begin
      oh = 8'h01 << (g % 8);
      add(1, 8'hFF, 0, oh, 3'(g % 8), 1, 0);
      add(1, 8'hFF, 0, oh, 3'(g % 8), 1, 0);
      add(1, 8'hFF, 1, 8'h00, 3'(g % 8), 0, 0);
    end
    // DONE in IDLE does nothing (PTR=1, idx=0).
    add(1, 8'h00, 1, 8'h00, 0, 0, 0);
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    // Grant 5 so PTR becomes 6, then sparse wrap to 0, then 1.
    add(1, 8'h20, 0, 8'h20, 5, 1, 0);
    add(1, 8'h20, 1, 8'h00, 5, 0, 0);
    add(1, 8'h03, 0, 8'h01, 0, 1, 0);
    add(1, 8'h03, 1, 8'h00, 0, 0, 0);
    add(1, 8'h03, 0, 8'h02, 1, 1, 0);
    // Requester drops REQ mid-grant: grant held until DONE.
    add(1, 8'h00, 0, 8'h02, 1, 1, 0);
    add(1, 8'h00, 1, 8'h00, 1, 0, 0);

    foreach (vecs[k])
      step(k, vecs[k].rst_n, vecs[k].req, vecs[k].done, vecs[k].gnt, vecs[k].idx,
           vecs[k].valid, vecs[k].err);

    // Watchdog: 4 cycles of grant, error pulse, re-grant after one idle cycle.
    step(100, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    step(101, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    step(102, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    step(103, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    step(104, 1, 8'h08, 0, 8'h00, 3, 0, 1);
    step(105, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    // DONE in the 4th BUSY cycle wins over the timeout.
    step(106, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    step(107, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    step(108, 1, 8'h08, 0, 8'h08, 3, 1, 0);
    step(109, 1, 8'h00, 1, 8'h00, 3, 0, 0);
    step(110, 1, 8'h00, 0, 8'h00, 3, 0, 0);

    // Reset mid-BUSY drops grant and clears PTR (otherwise PTR=5 would pick 5).
    step(200, 1, 8'h10, 0, 8'h10, 4, 1, 0);
    step(201, 0, 8'h10, 0, 8'h00, 0, 0, 0);
    step(202, 1, 8'hFF, 0, 8'h01, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
